// File: rtl/qspi_rx_deserializer.sv
// QSPI receive deserializer: gathers 1/2/4-bit samples into bytes and hands them to a
// valid/ready consumer, counting down a byte budget and flagging dropped bytes.
module qspi_rx_deserializer #(
    parameter int LEN_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [LEN_W-1:0] byte_count,
    input  logic [2:0]       mode,
    input  logic             sample_en,
    input  logic [3:0]       io_in,
    output logic [7:0]       rx_data,
    output logic             rx_valid,
    input  logic             rx_ready,
    output logic             busy,
    output logic             done,
    output logic             overrun,
    output logic [1:0]       state_dbg
);

    // rx_valid/rx_ready: a byte moves on any rising edge where both are high; rx_data is
    // held while rx_valid is high and nothing new loads.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t           state_q;
    logic [1:0]       lanes_q;      // 0 single, 1 dual, 2 quad
    logic [LEN_W-1:0] remain_q;
    logic [2:0]       smp_cnt_q;
    logic [7:0]       shift_q;
    logic [7:0]       rx_data_q;
    logic             rx_valid_q;
    logic             busy_q;
    logic             done_q;
    logic             overrun_q;

    logic [7:0]       shift_d;
    logic             byte_last;
    logic [1:0]       mode_lanes;

    always_comb begin
        shift_d   = {shift_q[6:0], io_in[1]};
        byte_last = (smp_cnt_q == 3'd7);
        case (lanes_q)
            2'd1: begin
                shift_d   = {shift_q[5:0], io_in[1:0]};
                byte_last = (smp_cnt_q == 3'd3);
            end
            2'd2: begin
                shift_d   = {shift_q[3:0], io_in};
                byte_last = (smp_cnt_q == 3'd1);
            end
            default: ;
        endcase
    end

    always_comb begin
        case (mode)
            3'd1:    mode_lanes = 2'd1;
            3'd2:    mode_lanes = 2'd2;
            default: mode_lanes = 2'd0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            lanes_q    <= 2'd0;
            remain_q   <= '0;
            smp_cnt_q  <= 3'd0;
            shift_q    <= 8'h00;
            rx_data_q  <= 8'h00;
            rx_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (rx_valid_q && rx_ready) begin
                rx_valid_q <= 1'b0;
            end
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        overrun_q <= 1'b0;
                        smp_cnt_q <= 3'd0;
                        shift_q   <= 8'h00;
                        if (byte_count != '0) begin
                            state_q  <= ST_SHIFT;
                            lanes_q  <= mode_lanes;
                            remain_q <= byte_count;
                            busy_q   <= 1'b1;
                        end else begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                        end
                    end
                end
                ST_SHIFT: begin
                    if (sample_en) begin
                        shift_q <= shift_d;
                        if (byte_last) begin
                            smp_cnt_q <= 3'd0;
                            remain_q  <= remain_q - {{(LEN_W-1){1'b0}}, 1'b1};
                            // A load wins over the handshake clear above.
                            if (!rx_valid_q || rx_ready) begin
                                rx_data_q  <= shift_d;
                                rx_valid_q <= 1'b1;
                            end else begin
                                overrun_q <= 1'b1;
                            end
                            if (remain_q == {{(LEN_W-1){1'b0}}, 1'b1}) begin
                                state_q <= ST_DONE;
                                busy_q  <= 1'b0;
                                done_q  <= 1'b1;
                            end
                        end else begin
                            smp_cnt_q <= smp_cnt_q + 3'd1;
                        end
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign overrun   = overrun_q;
    assign state_dbg = state_q;

endmodule
